// File: rtl/crop_writer.sv
// Crop writer: extracts an OUT_ROWS x OUT_COLS window at a programmable origin from a
// raster pixel stream, forwards it over AXI-Stream and tracks the largest forwarded pixel.
module crop_writer #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int IN_ROWS         = 64,
    parameter int IN_COLS         = 64,
    parameter int OUT_ROWS        = 10,
    parameter int OUT_COLS        = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ap_start,
    output logic                         ap_done,
    output logic                         ap_ready,
    output logic                         ap_idle,
    input  logic [$clog2(IN_ROWS)-1:0]   crop_row0,
    input  logic [$clog2(IN_COLS)-1:0]   crop_col0,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0]   s_axis_tdata,
    input  logic                         s_axis_tuser,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [PIXEL_BIT_WIDTH-1:0]   m_axis_tdata,
    output logic [PIXEL_BIT_WIDTH-1:0]   norm_max,
    output logic                         sof_err
);

    localparam int RW        = $clog2(IN_ROWS);
    localparam int CW        = $clog2(IN_COLS);
    localparam int OUT_TOTAL = OUT_ROWS * OUT_COLS;
    localparam int NW        = $clog2(OUT_TOTAL + 1);

    localparam logic [RW-1:0] ROW0_MAX   = RW'(IN_ROWS - OUT_ROWS);
    localparam logic [CW-1:0] COL0_MAX   = CW'(IN_COLS - OUT_COLS);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IN_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IN_COLS - 1);
    localparam logic [RW:0]   OUT_ROWS_W = (RW + 1)'(OUT_ROWS);
    localparam logic [CW:0]   OUT_COLS_W = (CW + 1)'(OUT_COLS);
    localparam logic [NW-1:0] OUT_LAST   = NW'(OUT_TOTAL - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_SOF = 2'd1;
    localparam logic [1:0] S_STREAM   = 2'd2;
    localparam logic [1:0] S_DRAIN    = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [RW-1:0]              row0_q, row0_d, row_q, row_d, cur_row;
    logic [CW-1:0]              col0_q, col0_d, col_q, col_d, cur_col;
    logic [NW-1:0]              cnt_q, cnt_d, cnt_base;
    logic [PIXEL_BIT_WIDTH-1:0] tdata_q, tdata_d, max_q, max_d, max_base;
    logic                       tvalid_q, tvalid_d;
    logic                       sof_err_q, sof_err_d;
    logic                       done_q, done_d;
    logic                       streaming, restart, proc_beat, in_win;
    logic                       out_ready, s_ready, step, load;

    // A tuser beat always restarts the raster at (0,0), whether it is the awaited SOF or a stray one.
    assign streaming = (state_q == S_WAIT_SOF) || (state_q == S_STREAM);
    assign restart   = streaming && s_axis_tuser;
    assign proc_beat = (state_q == S_STREAM) || restart;
    assign cur_row   = restart ? '0 : row_q;
    assign cur_col   = restart ? '0 : col_q;
    assign cnt_base  = restart ? '0 : cnt_q;
    assign max_base  = restart ? '0 : max_q;

    assign in_win = proc_beat
                 && (cur_row >= row0_q) && ({1'b0, cur_row} < ({1'b0, row0_q} + OUT_ROWS_W))
                 && (cur_col >= col0_q) && ({1'b0, cur_col} < ({1'b0, col0_q} + OUT_COLS_W));

    // Only window pixels need room in the output register; everything else is swallowed freely.
    assign out_ready = !tvalid_q || m_axis_tready;
    assign s_ready   = streaming && (!in_win || out_ready);
    assign step      = s_axis_tvalid && s_ready && proc_beat;
    assign load      = step && in_win;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        row0_d    = row0_q;
        col0_d    = col0_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        sof_err_d = sof_err_q;
        done_d    = 1'b0;
        tvalid_d  = tvalid_q;
        tdata_d   = tdata_q;

        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = s_axis_tdata;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    row0_d    = (crop_row0 > ROW0_MAX) ? ROW0_MAX : crop_row0;
                    col0_d    = (crop_col0 > COL0_MAX) ? COL0_MAX : crop_col0;
                    row_d     = '0;
                    col_d     = '0;
                    cnt_d     = '0;
                    max_d     = '0;
                    sof_err_d = 1'b0;
                    state_d   = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF, S_STREAM: begin
                if (step) begin
                    if (state_q == S_STREAM && s_axis_tuser && (row_q != '0 || col_q != '0))
                        sof_err_d = 1'b1;
                    if (cur_col == COL_LAST) begin
                        col_d = '0;
                        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
                    end else begin
                        col_d = cur_col + CW'(1);
                        row_d = cur_row;
                    end
                    cnt_d   = cnt_base;
                    max_d   = max_base;
                    state_d = S_STREAM;
                    if (load) begin
                        cnt_d = cnt_base + NW'(1);
                        max_d = (s_axis_tdata > max_base) ? s_axis_tdata : max_base;
                        if (cnt_base == OUT_LAST)
                            state_d = S_DRAIN;
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            row0_q    <= '0;
            col0_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            cnt_q     <= '0;
            max_q     <= '0;
            sof_err_q <= 1'b0;
            done_q    <= 1'b0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            row0_q    <= row0_d;
            col0_q    <= col0_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            sof_err_q <= sof_err_d;
            done_q    <= done_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
        end
    end

    assign ap_done       = done_q;
    assign ap_ready      = (state_q == S_IDLE);
    assign ap_idle       = (state_q == S_IDLE);
    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign norm_max      = max_q;
    assign sof_err       = sof_err_q;

endmodule
